circuito_exp5: RTL and testbench

Sequence-memory game core (Genius style) for the lab board. A fixed 16-entry ROM holds the target sequence. The player repeats a growing prefix (1, then 2, … up to 16 plays) on four one-hot switches, and each play has a timeout. The block drives the game-result outputs plus debug signals for the board's 7-segment displays and LEDs.

---
 rtl/circuito_exp5_pkg.sv | 56 +++++
 rtl/circuito_exp5_hexa7seg.sv | 32 +++
 rtl/circuito_exp5.sv | 158 +++++++++++++++
 tb/tb_circuito_exp5.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/circuito_exp5_pkg.sv
// Shared constants for the sequence-memory game: state codes, target ROM, timeout length.
package circuito_exp5_pkg;

  localparam int unsigned DATA_W         = 4;
  localparam int unsigned ADDR_W         = 4;
  localparam int unsigned ST_W           = 4;
  localparam int unsigned SEG_W          = 7;
  localparam int unsigned TMR_W          = 13;
  localparam int unsigned TIMEOUT_CYCLES = 5000;

  // State codes double as the hex digit shown on the state display
  localparam logic [3:0] S_INICIAL     = 4'h0;
  localparam logic [3:0] S_PREPARA     = 4'h1;
  localparam logic [3:0] S_ESPERA      = 4'h2;
  localparam logic [3:0] S_COMPARA     = 4'h4;
  localparam logic [3:0] S_PROXIMO     = 4'h5;
  localparam logic [3:0] S_NOVA_RODADA = 4'h6;
  localparam logic [3:0] S_FIM_ACERTO  = 4'hA;
  localparam logic [3:0] S_FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] S_FIM_ERRO    = 4'hE;

  // Control word from the FSM to the datapath
  typedef struct packed {
    logic clr;
    logic tmr_inc;
    logic load;
    logic inc_end;
    logic nova_rodada;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] rom_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = 4'h1;
    case (addr)
      4'h0: v = 4'h1;
      4'h1: v = 4'h2;
      4'h2: v = 4'h4;
      4'h3: v = 4'h8;
      4'h4: v = 4'h4;
      4'h5: v = 4'h2;
      4'h6: v = 4'h1;
      4'h7: v = 4'h1;
      4'h8: v = 4'h2;
      4'h9: v = 4'h2;
      4'hA: v = 4'h4;
      4'hB: v = 4'h4;
      4'hC: v = 4'h8;
      4'hD: v = 4'h8;
      4'hE: v = 4'h1;
      4'hF: v = 4'h4;
      default: v = 4'h1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/circuito_exp5_hexa7seg.sv
// Hex digit to active-low 7-segment decoder, bit order gfedcba.
module hexa7seg
  import circuito_exp5_pkg::*;
(
  input  logic [DATA_W-1:0] hexa,
  output logic [SEG_W-1:0]  display
);

  always_comb begin
    display = 7'h7F;
    case (hexa)
      4'h0: display = ~7'h3F;
      4'h1: display = ~7'h06;
      4'h2: display = ~7'h5B;
      4'h3: display = ~7'h4F;
      4'h4: display = ~7'h66;
      4'h5: display = ~7'h6D;
      4'h6: display = ~7'h7D;
      4'h7: display = ~7'h07;
      4'h8: display = ~7'h7F;
      4'h9: display = ~7'h6F;
      4'hA: display = ~7'h77;
      4'hB: display = ~7'h7C;
      4'hC: display = ~7'h39;
      4'hD: display = ~7'h5E;
      4'hE: display = ~7'h79;
      4'hF: display = ~7'h71;
      default: display = 7'h7F;
    endcase
  end

endmodule

// File: rtl/circuito_exp5.sv
// Genius-style sequence game: control FSM plus datapath (address, round, play, timeout).
module circuito_exp5
  import circuito_exp5_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [DATA_W-1:0] chaves,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic [DATA_W-1:0] leds,
  output logic              db_igual,
  output logic              db_tem_jogada,
  output logic              db_endmenorquelimite,
  output logic              db_clock,
  output logic [SEG_W-1:0]  db_contagem,
  output logic [SEG_W-1:0]  db_memoria,
  output logic [SEG_W-1:0]  db_jogadafeita,
  output logic [SEG_W-1:0]  db_limite,
  output logic [SEG_W-1:0]  db_estado,
  output logic [SEG_W-1:0]  db_timeout
);

  logic [ST_W-1:0]   estado, prox;
  ctrl_t             ctrl;
  logic [ADDR_W-1:0] endereco, limite;
  logic [DATA_W-1:0] jogada, chaves_q, memoria;
  logic [TMR_W-1:0]  tmr;
  logic              tinha_jogada, timeout_q;
  logic              fim_tmr, end_igual_lim;

  // ---------------- datapath ----------------
  assign memoria              = rom_read(endereco);
  assign db_igual             = (jogada == memoria);
  assign db_endmenorquelimite = (endereco < limite);
  assign end_igual_lim        = (endereco == limite);
  assign fim_tmr              = (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
  assign db_tem_jogada        = (|chaves_q) & ~tinha_jogada;
  assign leds                 = jogada;
  assign db_clock             = clock;

  // Switches are sampled first so a play is seen one cycle after the press
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chaves_q     <= '0;
      tinha_jogada <= 1'b0;
    end else begin
      chaves_q     <= chaves;
      tinha_jogada <= |chaves_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco <= '0;
      limite   <= '0;
      jogada   <= '0;
      tmr      <= '0;
    end else if (ctrl.clr) begin
      endereco <= '0;
      limite   <= '0;
      jogada   <= '0;
      tmr      <= '0;
    end else begin
      if (ctrl.load)
        jogada <= chaves_q;
      if (ctrl.inc_end)
        endereco <= endereco + ADDR_W'(1);
      if (ctrl.nova_rodada) begin
        limite   <= limite + ADDR_W'(1);
        endereco <= '0;
      end
      if (ctrl.load || ctrl.nova_rodada)
        tmr <= '0;
      else if (ctrl.tmr_inc)
        tmr <= tmr + TMR_W'(1);
    end
  end

  // ---------------- control unit ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estado <= S_INICIAL;
    else
      estado <= prox;
  end

  always_comb begin
    prox = estado;
    ctrl = '0;
    case (estado)
      S_INICIAL:
        if (iniciar) prox = S_PREPARA;
      S_PREPARA: begin
        ctrl.clr = 1'b1;
        prox     = S_ESPERA;
      end
      S_ESPERA: begin
        // A play in the same cycle as the timeout wins
        if (db_tem_jogada) begin
          ctrl.load = 1'b1;
          prox      = S_COMPARA;
        end else if (fim_tmr) begin
          prox = S_FIM_TIMEOUT;
        end else begin
          ctrl.tmr_inc = 1'b1;
        end
      end
      S_COMPARA: begin
        if (!db_igual)
          prox = S_FIM_ERRO;
        else if (!end_igual_lim)
          prox = S_PROXIMO;
        else if (limite == ADDR_W'(15))
          prox = S_FIM_ACERTO;
        else
          prox = S_NOVA_RODADA;
      end
      S_PROXIMO: begin
        ctrl.inc_end = 1'b1;
        prox         = S_ESPERA;
      end
      S_NOVA_RODADA: begin
        ctrl.nova_rodada = 1'b1;
        prox             = S_ESPERA;
      end
      S_FIM_ACERTO, S_FIM_ERRO, S_FIM_TIMEOUT:
        if (iniciar) prox = S_PREPARA;
      default:
        prox = S_INICIAL;
    endcase
  end

  // Result flags are decoded from the next state so they line up with estado
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pronto    <= (prox == S_FIM_ACERTO) || (prox == S_FIM_ERRO) || (prox == S_FIM_TIMEOUT);
      acertou   <= (prox == S_FIM_ACERTO);
      errou     <= (prox == S_FIM_ERRO) || (prox == S_FIM_TIMEOUT);
      timeout_q <= (prox == S_FIM_TIMEOUT);
    end
  end

  // ---------------- debug displays ----------------
  hexa7seg u_hex_contagem (.hexa(endereco),             .display(db_contagem));
  hexa7seg u_hex_memoria  (.hexa(memoria),              .display(db_memoria));
  hexa7seg u_hex_jogada   (.hexa(jogada),               .display(db_jogadafeita));
  hexa7seg u_hex_limite   (.hexa(limite),               .display(db_limite));
  hexa7seg u_hex_estado   (.hexa(estado),               .display(db_estado));
  hexa7seg u_hex_timeout  (.hexa({3'b000, timeout_q}),  .display(db_timeout));

endmodule

// File: tb/tb_circuito_exp5.sv
// Randomized bench for circuito_exp5 against a game-level reference model.
module tb_circuito_exp5;

  logic       clock = 1'b0;
  logic       reset, iniciar;
  logic [3:0] chaves;
  logic       pronto, acertou, errou;
  logic [3:0] leds;
  logic       db_igual, db_tem_jogada, db_endmenorquelimite, db_clock;
  logic [6:0] db_contagem, db_memoria, db_jogadafeita, db_limite, db_estado, db_timeout;

  int n_chk  = 0;
  int n_pass = 0;
  int n_pulse = 0;

  logic [3:0] rom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
  // Lit segments (gfedcba) for hex digits 0..F
  logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  circuito_exp5 dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .pronto(pronto), .acertou(acertou), .errou(errou), .leds(leds),
    .db_igual(db_igual), .db_tem_jogada(db_tem_jogada),
    .db_endmenorquelimite(db_endmenorquelimite), .db_clock(db_clock),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_jogadafeita(db_jogadafeita),
    .db_limite(db_limite), .db_estado(db_estado), .db_timeout(db_timeout)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (db_tem_jogada) n_pulse++;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    return ~seg_on[v];
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    step(1);
  endtask

  task automatic press(input logic [3:0] v);
    int hold, gap;
    hold = $urandom_range(1, 6);
    gap  = $urandom_range(4, 7);
    chaves = v;
    step(hold);
    chaves = 4'h0;
    step(gap);
  endtask

  // Plays growing prefixes; each play is wrong with probability wrong_pct percent
  task automatic run_game(input int wrong_pct);
    logic       done, win;
    logic [3:0] v, last;
    int         exp_lim, exp_end;
    done = 1'b0; last = 4'h0; exp_lim = 0; exp_end = 0;
    pulse_iniciar();
    for (int r = 0; r < 16 && !done; r++) begin
      for (int i = 0; i <= r && !done; i++) begin
        v = rom[i];
        if (int'($urandom_range(0, 99)) < wrong_pct) begin
          do v = 4'($urandom_range(1, 15)); while (v == rom[i]);
        end
        press(v);
        last = v; exp_lim = r; exp_end = i;
        if (v != rom[i]) done = 1'b1;
      end
    end
    win = !done;
    step(2);
    check("game_pronto",   16'(pronto),  16'(1));
    check("game_acertou",  16'(acertou), 16'(win));
    check("game_errou",    16'(errou),   16'(!win));
    check("game_leds",     16'(leds),    16'(last));
    check("game_limite",   16'(db_limite),   16'(hex7(4'(exp_lim))));
    check("game_contagem", 16'(db_contagem), 16'(hex7(4'(exp_end))));
    check("game_estado",   16'(db_estado),   16'(hex7(win ? 4'hA : 4'hE)));
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; chaves = 4'h0;
    step(10);
    check("rst_estado",   16'(db_estado),      16'(hex7(4'h0)));
    check("rst_pronto",   16'(pronto),         16'(0));
    check("rst_acertou",  16'(acertou),        16'(0));
    check("rst_errou",    16'(errou),          16'(0));
    check("rst_leds",     16'(leds),           16'(0));
    check("rst_contagem", 16'(db_contagem),    16'(hex7(4'h0)));
    check("rst_limite",   16'(db_limite),      16'(hex7(4'h0)));
    check("rst_jogada",   16'(db_jogadafeita), 16'(hex7(4'h0)));
    check("rst_memoria",  16'(db_memoria),     16'(hex7(rom[0])));
    reset = 1'b0;
    step(2);

    // Round 1 with latency checks
    pulse_iniciar();
    check("espera_entry", 16'(db_estado), 16'(hex7(4'h2)));
    chaves = 4'h1;
    step(1);
    check("detect_pulse", 16'(db_tem_jogada), 16'(1));
    step(1);
    check("compara_state", 16'(db_estado),    16'(hex7(4'h4)));
    check("pulse_once",    16'(db_tem_jogada), 16'(0));
    check("igual_r1",      16'(db_igual),      16'(1));
    step(1);
    check("nova_rodada",   16'(db_estado), 16'(hex7(4'h6)));
    step(7);
    chaves = 4'h0;
    step(5);
    check("r1_limite",  16'(db_limite), 16'(hex7(4'h1)));
    check("r1_estado",  16'(db_estado), 16'(hex7(4'h2)));
    check("r1_leds",    16'(leds),      16'(1));
    check("r1_menor",   16'(db_endmenorquelimite), 16'(1));

    // Wrong first play of round 2
    chaves = 4'h2;
    step(3);
    chaves = 4'h0;
    step(3);
    check("err_pronto",  16'(pronto),    16'(1));
    check("err_errou",   16'(errou),     16'(1));
    check("err_acertou", 16'(acertou),   16'(0));
    check("err_estado",  16'(db_estado), 16'(hex7(4'hE)));
    check("err_leds",    16'(leds),      16'(2));

    // Full correct game
    run_game(0);
    check("win_limite_F", 16'(db_limite), 16'(hex7(4'hF)));

    // iniciar held in a final state restarts only once
    iniciar = 1'b1;
    step(6);
    check("hold_iniciar", 16'(db_estado), 16'(hex7(4'h2)));
    check("hold_pronto",  16'(pronto),    16'(0));
    iniciar = 1'b0;

    // Exact timeout
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    pulse_iniciar();
    step(4999);
    check("tmo_before", 16'(db_estado), 16'(hex7(4'h2)));
    step(1);
    check("tmo_estado",  16'(db_estado),  16'(hex7(4'hD)));
    check("tmo_errou",   16'(errou),      16'(1));
    check("tmo_pronto",  16'(pronto),     16'(1));
    check("tmo_acertou", 16'(acertou),    16'(0));
    check("tmo_flag",    16'(db_timeout), 16'(hex7(4'h1)));

    // Long hold gives one pulse; play outside ESPERA is ignored
    n_pulse = 0;
    chaves = 4'h1;
    step(50);
    chaves = 4'h0;
    step(3);
    check("hold_pulses", 16'(n_pulse),   16'(1));
    check("hold_ignore", 16'(db_estado), 16'(hex7(4'hD)));

    // Randomized games
    for (int g = 0; g < 6; g++)
      run_game((g < 3) ? 3 : 25);

    // Asynchronous reset mid-round
    pulse_iniciar();
    press(rom[0]);
    press(rom[0]);
    #2 reset = 1'b1;
    #1;
    check("async_estado", 16'(db_estado), 16'(hex7(4'h0)));
    check("async_limite", 16'(db_limite), 16'(hex7(4'h0)));
    check("async_leds",   16'(leds),      16'(0));
    step(1);
    reset = 1'b0;
    step(3);
    check("post_rst_idle", 16'(db_estado), 16'(hex7(4'h0)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
